// File: rtl/conv_load_sequencer.sv
// Drives weight and activation SRAM reads into L0 for each kernel position of a
// convolution, then hands off to the controller and clears between iterations.
module conv_load_sequencer #(
    parameter int row     = 8,
    parameter int num_inp = 64,
    parameter int kij_len = 9,
    parameter int addr_bw = 11,
    parameter int kij_bw  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               iter_done,
    input  logic               l0_full,
    output logic               cenw,
    output logic               ceni,
    output logic [addr_bw-1:0] Aw,
    output logic [addr_bw-1:0] Ai,
    output logic               w_x,
    output logic               l0_wr,
    output logic               iter_clr,
    output logic [kij_bw-1:0]  kij,
    output logic               busy,
    output logic               done
);

    localparam int cnt_bw = $clog2(((row > num_inp) ? row : num_inp) + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
        WAIT_ITER,
        CLEAR,
        DONE
    } state_t;

    state_t             state;
    logic [cnt_bw-1:0]  cnt;
    logic [addr_bw-1:0] aw_next;

    assign aw_next = addr_bw'(kij) * addr_bw'(row) + addr_bw'(cnt);

    // Abort shares the reset path so an in-flight l0_wr is dropped along with everything else.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state    <= IDLE;
            cnt      <= '0;
            cenw     <= 1'b1;
            ceni     <= 1'b1;
            Aw       <= '0;
            Ai       <= '0;
            w_x      <= 1'b0;
            l0_wr    <= 1'b0;
            iter_clr <= 1'b0;
            kij      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            l0_wr    <= ~cenw | ~ceni;
            iter_clr <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD_W;
                        kij   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                LOAD_W: begin
                    if (!l0_full) begin
                        cenw <= 1'b0;
                        w_x  <= 1'b1;
                        Aw   <= aw_next;
                        if (cnt == cnt_bw'(row - 1)) begin
                            cnt   <= '0;
                            state <= LOAD_X;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cenw <= 1'b1;
                    end
                end
                LOAD_X: begin
                    cenw <= 1'b1;
                    if (!l0_full) begin
                        ceni <= 1'b0;
                        w_x  <= 1'b0;
                        Ai   <= addr_bw'(cnt);
                        if (cnt == cnt_bw'(num_inp - 1)) begin
                            cnt   <= '0;
                            state <= WAIT_ITER;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        ceni <= 1'b1;
                    end
                end
                WAIT_ITER: begin
                    cenw <= 1'b1;
                    ceni <= 1'b1;
                    Ai   <= '0;
                    if (iter_done) begin
                        iter_clr <= 1'b1;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (kij == kij_bw'(kij_len - 1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        kij   <= kij + 1'b1;
                        cnt   <= '0;
                        state <= LOAD_W;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_load_sequencer.sv
// Randomized bench for conv_load_sequencer: a read-order scoreboard plus cycle
// rules (stall, l0_wr lag, clear/done handshake) checked every cycle.
module tb_conv_load_sequencer;

    localparam int ROW = 8;
    localparam int NINP = 64;
    localparam int KLEN = 9;
    localparam int PER_KIJ = ROW + NINP;
    localparam int TOTAL = PER_KIJ * KLEN;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        iter_done = 1'b0;
    logic        l0_full = 1'b0;
    logic        cenw, ceni, w_x, l0_wr, iter_clr, busy, done;
    logic [10:0] Aw, Ai;
    logic [3:0]  kij;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, written only by the monitor.
    bit active = 0, waiting = 0, prev_rd = 0, last_clr = 0, last_done = 0;
    int read_idx = 0, clears = 0, wr_cnt = 0, done_cnt = 0;

    // Stimulus controls, written only by the main sequence.
    int stall_mode = 0;
    bit noise_en = 0;
    int resp_mode = 0;

    conv_load_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .iter_done(iter_done), .l0_full(l0_full), .cenw(cenw), .ceni(ceni),
        .Aw(Aw), .Ai(Ai), .w_x(w_x), .l0_wr(l0_wr), .iter_clr(iter_clr),
        .kij(kij), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge; inputs seen then are the ones the edge used.
    always @(posedge clk) begin
        bit rd, rd_w, e_clr, new_active, in_kij;
        int r, kk;
        #1;
        rd_w = !cenw;
        rd = !cenw || !ceni;
        checkOutput("one_cen_low", int'(!cenw && !ceni), 0);
        if (reset || abort) begin
            checkOutput("rst_cenw", cenw, 1);
            checkOutput("rst_ceni", ceni, 1);
            checkOutput("rst_Aw", Aw, 0);
            checkOutput("rst_Ai", Ai, 0);
            checkOutput("rst_w_x", w_x, 0);
            checkOutput("rst_l0_wr", l0_wr, 0);
            checkOutput("rst_iter_clr", iter_clr, 0);
            checkOutput("rst_kij", kij, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            active = 0; waiting = 0; prev_rd = 0; last_clr = 0; last_done = 0;
            read_idx = 0; clears = 0; wr_cnt = 0;
        end else begin
            checkOutput("l0_wr", l0_wr, prev_rd);
            if (l0_wr) wr_cnt++;
            new_active = last_done ? 1'b0 : (active || start);
            checkOutput("busy", busy, new_active);
            e_clr = waiting && iter_done;
            checkOutput("iter_clr", iter_clr, e_clr);
            if (e_clr) begin
                waiting = 0;
                clears++;
                checkOutput("wr_per_kij", wr_cnt, PER_KIJ);
                wr_cnt = 0;
            end
            checkOutput("done", done, last_clr);
            last_done = last_clr;
            if (last_clr) begin
                done_cnt++;
                checkOutput("done_kij", kij, KLEN - 1);
                checkOutput("done_last_Aw", Aw, ROW * KLEN - 1);
                checkOutput("done_Ai", Ai, 0);
                checkOutput("done_reads", read_idx, TOTAL);
                read_idx = 0;
                clears = 0;
            end
            last_clr = e_clr && (clears == KLEN);
            in_kij = (read_idx % PER_KIJ) != 0;
            if (in_kij) checkOutput("rd_issue", rd, int'(!l0_full));
            else if (rd) checkOutput("rd_allowed", int'(active && !waiting && clears == read_idx / PER_KIJ), 1);
            kk = read_idx / PER_KIJ;
            r = read_idx % PER_KIJ;
            if (rd) begin
                checkOutput("rd_weight", rd_w, int'(r < ROW));
                checkOutput("rd_w_x", w_x, int'(r < ROW));
                if (r < ROW) checkOutput("rd_Aw", Aw, kk * ROW + r);
                else         checkOutput("rd_Ai", Ai, r - ROW);
                checkOutput("rd_kij", kij, kk);
                checkOutput("rd_stall_rule", l0_full, 0);
                read_idx++;
                if (read_idx % PER_KIJ == 0) waiting = 1;
            end else if (in_kij) begin
                if (r <= ROW) checkOutput("hold_Aw", Aw, kk * ROW + r - 1);
                else          checkOutput("hold_Ai", Ai, r - ROW - 1);
            end
            prev_rd = rd;
            active = new_active;
        end
    end

    // Controller stand-in: answers each WAIT_ITER after a delay, optionally pulsing iter_done at random otherwise.
    always @(negedge clk) begin
        int wait_cnt;
        iter_done = 1'b0;
        if (resp_mode == 2) begin
            iter_done = waiting;
        end else if (waiting) begin
            if (wait_cnt == 4) begin
                iter_done = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            if (noise_en) iter_done = ($urandom_range(0, 5) == 0);
        end
    end

    // L0 back-pressure: off, random, or a single 3-cycle stall right after the Ai=20 read of kij 0.
    always @(negedge clk) begin
        int stall_left;
        bit stall_used;
        if (stall_mode == 2 && !stall_used && read_idx == ROW + 21) begin
            stall_left = 3;
            stall_used = 1;
        end
        if (stall_mode == 1) begin
            l0_full = ($urandom_range(0, 3) == 0);
        end else begin
            l0_full = (stall_left > 0);
            if (stall_left > 0) stall_left--;
        end
    end

    task automatic applyStimulus(input int md, input bit noise, input int abort_at, input int restart_at);
        int d0;
        bit ab, sa;
        stall_mode = md;
        noise_en = noise;
        d0 = done_cnt;
        ab = 0;
        sa = 0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (ab || done_cnt != d0) break;
            if (restart_at >= 0 && !sa && read_idx >= restart_at) begin
                start = 1'b1;
                sa = 1;
            end
            if (abort_at >= 0 && read_idx == abort_at) begin
                abort = 1'b1;
                ab = 1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (6) @(negedge clk);
        if (abort_at >= 0) begin
            checkOutput("abort_seen", ab, 1);
            checkOutput("abort_no_done", done_cnt - d0, 0);
        end else begin
            checkOutput("single_done", done_cnt - d0, 1);
        end
    endtask

    initial begin
        int d0;
        bit hit;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(0, 0, -1, -1);
        applyStimulus(2, 1, -1, 4 * PER_KIJ + 3);
        applyStimulus(1, 1, 2 * PER_KIJ + ROW + 11, -1);
        applyStimulus(1, 1, -1, -1);

        // Reset lands on the same edge as the first iter_done in WAIT_ITER.
        stall_mode = 0;
        noise_en = 0;
        resp_mode = 2;
        d0 = done_cnt;
        hit = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
            @(negedge clk);
            if (waiting) begin
                reset = 1'b1;
                hit = 1;
            end
        end
        @(negedge clk);
        reset = 1'b0;
        resp_mode = 0;
        repeat (5) @(negedge clk);
        checkOutput("reset_in_wait_seen", hit, 1);
        checkOutput("reset_no_done", done_cnt - d0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
